// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the clock divider bank.
//   DIV_W_DEFAULT       default half-period register width
//   DEFAULT_HALF_16M67  reset half-period (100 MHz / 6 = 16.67 MHz)
//   HALF_*              half-period values for common rates off 100 MHz
package clk_div_pkg;

  localparam int unsigned DIV_W_DEFAULT      = 16;
  localparam int unsigned DEFAULT_HALF_16M67 = 3;

  localparam int unsigned HALF_25MHZ         = 2;
  localparam int unsigned HALF_6M25HZ        = 8;
  // Needs DIV_W >= 16.
  localparam int unsigned HALF_1KHZ          = 50000;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with a shadowed, boundary-applied half-period.
//   basys_clk  system clock
//   reset      async active-high reset
//   resync     sync phase realignment (zero the waveform, apply any pending value)
//   wr_sel     write strobe for this channel
//   wr_half    new half-period (0 = disabled)
//   clk_out    divided square wave (period 2*active)
//   tick       one-cycle pulse in the first high cycle of clk_out
//   pending    shadow value not yet applied
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W        = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_16M67
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic             resync,
  input  logic             wr_sel,
  input  logic [DIV_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_boundary;
  logic             w_apply;
  logic             w_run;
  logic             w_wrap;

  // Start of a period (about to rise) or idle while disabled.
  assign w_boundary = (r_count == '0) && !r_clk;
  assign w_apply    = r_pend && (resync || w_boundary);

  // A boundary that is about to load 0 must not begin a new high phase,
  // otherwise a one-cycle runt would precede the disable.
  assign w_run = (r_active != '0) && !(w_boundary && r_pend && (r_shadow == '0));

  // >= rather than == so a count left above a smaller divisor still wraps.
  assign w_wrap = r_count >= (r_active - DIV_W'(1));

  // Waveform generation.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else if (resync || !w_run) begin
      r_count <= '0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + DIV_W'(1);
      if (r_count == '0) begin
        r_clk <= ~r_clk;
      end
      r_tick <= w_boundary;
    end
  end

  // Divisor shadowing; a write in an apply cycle lands in shadow and stays pending.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      r_active <= DIV_W'(DEFAULT_HALF);
      r_shadow <= DIV_W'(DEFAULT_HALF);
      r_pend   <= 1'b0;
    end else begin
      if (w_apply) begin
        r_active <= r_shadow;
        r_pend   <= 1'b0;
      end
      if (wr_sel) begin
        r_shadow <= wr_half;
        r_pend   <= 1'b1;
      end
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign pending = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of N_CH independent programmable clock dividers.
//   basys_clk  100 MHz system clock
//   reset      async active-high reset
//   resync     sync phase realignment of all channels
//   wr_en      divisor write strobe
//   wr_ch      target channel (values >= N_CH are ignored)
//   wr_half    new half-period (0 = disabled)
//   clk_out    divided square waves, one per channel
//   tick       one-cycle pulse per clk_out rising edge (preferred as clock enable)
//   pending    per-channel shadow divisor not yet applied
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int unsigned N_CH         = 4,
  parameter  int unsigned DIV_W        = DIV_W_DEFAULT,
  parameter  int unsigned DEFAULT_HALF = DEFAULT_HALF_16M67,
  localparam int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic             resync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0] w_wr_sel;

  // Only indices below N_CH are decoded, so out-of-range wr_ch selects nothing.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] SEL = CH_W'(i);

    assign w_wr_sel[i] = wr_en && (wr_ch == SEL);

    clk_div_chan #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .basys_clk (basys_clk),
      .reset     (reset),
      .resync    (resync),
      .wr_sel    (w_wr_sel[i]),
      .wr_half   (wr_half),
      .clk_out   (clk_out[i]),
      .tick      (tick[i]),
      .pending   (pending[i])
    );
  end

endmodule
